// File: rtl/intra_delay_pkg.sv
// intra_delay_reg shared types and helpers.
// Holds the state enum, the counter sizing function and the legal DELAY range.
package intra_delay_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int DELAY_MIN = 1;
    localparam int DELAY_MAX = 1023;

    // The counter holds DELAY-1 at most; keep at least one bit for DELAY=1.
    function automatic int cnt_width(input int d);
        int w;
        w = $clog2(d);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/intra_delay_chan.sv
// One intra_delay_reg channel.
// Captures data on load and commits it DELAY cycles later, optionally re-arming.
module intra_delay_chan
    import intra_delay_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter int               DELAY    = 10,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             repeat_en,
    output logic [WIDTH-1:0] value,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    localparam int            CW     = cnt_width(DELAY);
    localparam logic [CW-1:0] RELOAD = CW'(DELAY - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] hold, hold_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             commit;
    logic             reject;

    always_comb begin
        state_nx = state;
        hold_nx  = hold;
        cnt_nx   = cnt;
        commit   = 1'b0;
        reject   = 1'b0;
        unique case (state)
            IDLE: begin
                if (load) begin
                    hold_nx  = load_data;
                    cnt_nx   = RELOAD;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - ONE;
                    reject = load;
                end else begin
                    commit = 1'b1;
                    // A load on the commit edge chains straight into a new wait.
                    if (load) begin
                        hold_nx = load_data;
                        cnt_nx  = RELOAD;
                    end else if (repeat_en) begin
                        cnt_nx = RELOAD;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            hold    <= '0;
            cnt     <= '0;
            value   <= INIT_VAL;
            valid   <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nx;
            hold    <= hold_nx;
            cnt     <= cnt_nx;
            done    <= commit;
            overrun <= reject;
            if (commit) begin
                value <= hold;
                valid <= 1'b1;
            end
        end
    end

    assign busy = (state == WAIT);

endmodule

// File: rtl/intra_delay_reg.sv
// Multi-channel clocked replacement for "reg = #delay value".
// Each channel is an independent intra_delay_chan on its own bus slice.
module intra_delay_reg
    import intra_delay_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter int               DELAY    = 10,
    parameter int               CHANNELS = 1,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_data,
    input  logic [CHANNELS-1:0]       repeat_en,
    output logic [CHANNELS*WIDTH-1:0] value,
    output logic [CHANNELS-1:0]       valid,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS-1:0]       overrun
);

    if (DELAY < DELAY_MIN || DELAY > DELAY_MAX) begin : g_bad_delay
        $error("intra_delay_reg: DELAY out of range 1..1023");
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        intra_delay_chan #(
            .WIDTH    (WIDTH),
            .DELAY    (DELAY),
            .INIT_VAL (INIT_VAL)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .load      (load[c]),
            .load_data (load_data[c*WIDTH +: WIDTH]),
            .repeat_en (repeat_en[c]),
            .value     (value[c*WIDTH +: WIDTH]),
            .valid     (valid[c]),
            .busy      (busy[c]),
            .done      (done[c]),
            .overrun   (overrun[c])
        );
    end

endmodule

// File: tb/tb_intra_delay_reg.sv
// Directed bench for intra_delay_reg.
// Unit a: single channel, DELAY=10. Unit b: three channels, DELAY=1.
module tb_intra_delay_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        a_load = 1'b0;
    logic [3:0]  a_data = '0;
    logic        a_rep = 1'b0;
    logic [3:0]  a_value;
    logic        a_valid, a_busy, a_done, a_ovr;

    logic [2:0]  b_load = '0;
    logic [11:0] b_data = '0;
    logic [2:0]  b_rep = '0;
    logic [11:0] b_value;
    logic [2:0]  b_valid, b_busy, b_done, b_ovr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    intra_delay_reg #(
        .WIDTH (4), .DELAY (10), .CHANNELS (1), .INIT_VAL (4'h0)
    ) dut_a (
        .clk (clk), .reset (reset),
        .load (a_load), .load_data (a_data), .repeat_en (a_rep),
        .value (a_value), .valid (a_valid), .busy (a_busy),
        .done (a_done), .overrun (a_ovr)
    );

    intra_delay_reg #(
        .WIDTH (4), .DELAY (1), .CHANNELS (3), .INIT_VAL (4'h0)
    ) dut_b (
        .clk (clk), .reset (reset),
        .load (b_load), .load_data (b_data), .repeat_en (b_rep),
        .value (b_value), .valid (b_valid), .busy (b_busy),
        .done (b_done), .overrun (b_ovr)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held three cycles, then the first cycle after release.
        for (int i = 0; i < 4; i++) begin
            if (i == 3) reset = 1'b0;
            step();
            chk("rst_value", a_value, 4'h0);
            chk("rst_valid", a_valid, 1'b0);
            chk("rst_busy",  a_busy,  1'b0);
            chk("rst_done",  a_done,  1'b0);
            chk("rst_b_val", b_value, 12'h000);
            chk("rst_b_vld", b_valid, 3'b000);
        end

        // Basic commit; data changes after acceptance.
        a_load = 1'b1; a_data = 4'h5;
        step();
        chk("basic_busy0", a_busy, 1'b1);
        a_load = 1'b0; a_data = 4'hA;
        for (int e = 1; e <= 9; e++) begin
            step();
            chk("basic_val_pre", a_value, 4'h0);
            chk("basic_vld_pre", a_valid, 1'b0);
            chk("basic_done_pre", a_done, 1'b0);
            chk("basic_busy_pre", a_busy, 1'b1);
        end
        step();
        chk("basic_val10", a_value, 4'h5);
        chk("basic_vld10", a_valid, 1'b1);
        chk("basic_done10", a_done, 1'b1);
        chk("basic_busy10", a_busy, 1'b0);
        step();
        chk("basic_done11", a_done, 1'b0);
        chk("basic_val11", a_value, 4'h5);

        // Overrun: second load mid-wait is rejected.
        a_load = 1'b1; a_data = 4'h3;
        step();
        a_load = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            a_load = (e == 4);
            a_data = (e == 4) ? 4'h7 : 4'h0;
            step();
            chk("ovr_pulse", a_ovr, (e == 4) ? 1'b1 : 1'b0);
            chk("ovr_value", a_value, (e >= 10) ? 4'h3 : 4'h5);
            chk("ovr_done", a_done, (e == 10) ? 1'b1 : 1'b0);
        end
        a_load = 1'b0;
        chk("ovr_busy_end", a_busy, 1'b0);

        // Repeat mode with load-through at edge 30 and disable at 45.
        a_rep = 1'b1; a_load = 1'b1; a_data = 4'h5;
        step();
        a_load = 1'b0; a_data = 4'h0;
        for (int e = 1; e <= 29; e++) begin
            step();
            chk("rep_done", a_done, (e == 10 || e == 20) ? 1'b1 : 1'b0);
            chk("rep_busy", a_busy, 1'b1);
        end
        chk("rep_value29", a_value, 4'h5);
        a_load = 1'b1; a_data = 4'h9;
        step();
        chk("lt_done30", a_done, 1'b1);
        chk("lt_value30", a_value, 4'h5);
        chk("lt_ovr30", a_ovr, 1'b0);
        a_load = 1'b0; a_data = 4'h0;
        for (int e = 31; e <= 52; e++) begin
            a_rep = (e < 45);
            step();
            chk("lt_done", a_done, (e == 40 || e == 50) ? 1'b1 : 1'b0);
            chk("lt_busy", a_busy, (e < 50) ? 1'b1 : 1'b0);
            chk("lt_value", a_value, (e >= 40) ? 4'h9 : 4'h5);
            chk("lt_ovr", a_ovr, 1'b0);
        end

        // Reset mid-operation aborts the pending commit.
        a_rep = 1'b0; a_load = 1'b1; a_data = 4'h6;
        step();
        a_load = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            reset = (e == 5);
            step();
            if (e >= 5) begin
                chk("mid_value", a_value, 4'h0);
                chk("mid_valid", a_valid, 1'b0);
                chk("mid_busy", a_busy, 1'b0);
                chk("mid_done", a_done, 1'b0);
            end
        end
        reset = 1'b0;

        // Multi-channel, DELAY=1: channels 0 and 2 load together.
        b_load = 3'b101; b_data = 12'hF01;
        step();
        chk("mc_busy0", b_busy, 3'b101);
        chk("mc_val0", b_value, 12'h000);
        b_load = 3'b000; b_data = 12'h000;
        step();
        chk("mc_value", b_value, 12'hF01);
        chk("mc_valid", b_valid, 3'b101);
        chk("mc_done", b_done, 3'b101);
        chk("mc_busy1", b_busy, 3'b000);
        step();
        chk("mc_done2", b_done, 3'b000);
        chk("mc_value2", b_value, 12'hF01);

        // Repeat with DELAY=1 commits on every edge.
        b_rep = 3'b010; b_load = 3'b010; b_data = 12'h0C0;
        step();
        b_load = 3'b000; b_data = 12'h000;
        for (int e = 1; e <= 3; e++) begin
            step();
            chk("mc_rep_done", b_done, 3'b010);
            chk("mc_rep_value", b_value, 12'hFC1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
